// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet controller.
//   state_e      : FSM state encoding, 3-bit binary, DECODE_ADDRESS = 0
//   ADDR_*       : destination address values; ADDR_INVALID is dropped
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_e;

  localparam logic [1:0] ADDR_P0      = 2'd0;
  localparam logic [1:0] ADDR_P1      = 2'd1;
  localparam logic [1:0] ADDR_P2      = 2'd2;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

endpackage

// File: rtl/router_fsm_if.sv
// Handshake/strobe bundle between the packet source, the router datapath
// (register block, router_sync, FIFOs) and router_fsm.
//   slave  : the FSM side (samples source/datapath status, drives strobes)
//   master : the environment side (drives status, observes strobes)
interface router_fsm_if;
  // source / datapath status
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  // FSM strobes
  logic       busy;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       write_enb_reg;
  logic       rst_int_reg;

  modport slave (
    input  pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
    output busy, detect_add, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg
  );

  modport master (
    output pkt_valid, data_in, parity_done, low_pkt_valid, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
    input  busy, detect_add, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg
  );
endinterface

// File: rtl/router_fsm.sv
// Packet-level controller for the 1x3 router.
// Sequences header decode, first-data load, payload load, full stall,
// parity load and parity check; latches the destination address.
// Ports:
//   clock  : system clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : router_fsm_if.slave (status in, state strobes out)
// Strobes are registered from the next state, so they equal a decode of
// the current state with no added latency.
module router_fsm
  import router_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  router_fsm_if.slave bus
);

  state_e     r_state;
  state_e     w_nxt;
  logic [1:0] r_addr_q;

  logic r_busy, r_detect_add, r_lfd, r_ld, r_laf, r_full, r_wen, r_rst_int;

  // Padded to 4 entries so address 3 selects a constant 0.
  logic [3:0] w_empty_vec;
  logic [3:0] w_soft_vec;
  logic       w_empty_sel;
  logic       w_soft_sel;
  logic       w_empty_din;

  assign w_empty_vec = {1'b0, bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign w_soft_vec  = {1'b0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
  assign w_empty_sel = w_empty_vec[r_addr_q];
  assign w_soft_sel  = w_soft_vec[r_addr_q];
  // Header cycle: address not latched yet, so look at data_in directly.
  assign w_empty_din = w_empty_vec[bus.data_in];

  always_comb begin
    w_nxt = r_state;
    if (r_state != DECODE_ADDRESS && w_soft_sel) begin
      w_nxt = DECODE_ADDRESS;
    end else begin
      case (r_state)
        DECODE_ADDRESS:
          if (bus.pkt_valid && bus.data_in != ADDR_INVALID)
            w_nxt = w_empty_din ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        LOAD_FIRST_DATA:
          w_nxt = LOAD_DATA;
        LOAD_DATA:
          if (bus.fifo_full)       w_nxt = FIFO_FULL_STATE;
          else if (!bus.pkt_valid) w_nxt = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!bus.fifo_full) w_nxt = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (bus.parity_done)        w_nxt = DECODE_ADDRESS;
          else if (bus.low_pkt_valid) w_nxt = LOAD_PARITY;
          else                        w_nxt = LOAD_DATA;
        LOAD_PARITY:
          w_nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          w_nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:
          if (w_empty_sel) w_nxt = LOAD_FIRST_DATA;
        default:
          w_nxt = DECODE_ADDRESS;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= DECODE_ADDRESS;
      r_addr_q     <= ADDR_P0;
      r_detect_add <= 1'b1;
      r_busy       <= 1'b0;
      r_lfd        <= 1'b0;
      r_ld         <= 1'b0;
      r_laf        <= 1'b0;
      r_full       <= 1'b0;
      r_wen        <= 1'b0;
      r_rst_int    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == DECODE_ADDRESS && bus.pkt_valid)
        r_addr_q <= bus.data_in;
      r_detect_add <= (w_nxt == DECODE_ADDRESS);
      r_lfd        <= (w_nxt == LOAD_FIRST_DATA);
      r_ld         <= (w_nxt == LOAD_DATA);
      r_full       <= (w_nxt == FIFO_FULL_STATE);
      r_laf        <= (w_nxt == LOAD_AFTER_FULL);
      r_rst_int    <= (w_nxt == CHECK_PARITY_ERROR);
      r_wen        <= (w_nxt == LOAD_DATA) || (w_nxt == LOAD_AFTER_FULL) ||
                      (w_nxt == LOAD_PARITY);
      r_busy       <= (w_nxt != DECODE_ADDRESS) && (w_nxt != LOAD_DATA);
    end
  end

  assign bus.busy          = r_busy;
  assign bus.detect_add    = r_detect_add;
  assign bus.lfd_state     = r_lfd;
  assign bus.ld_state      = r_ld;
  assign bus.laf_state     = r_laf;
  assign bus.full_state    = r_full;
  assign bus.write_enb_reg = r_wen;
  assign bus.rst_int_reg   = r_rst_int;

endmodule

// File: tb/tb_router_fsm.sv
module tb_router_fsm;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  router_fsm_if bus();
  router_fsm dut (.clock(clock), .resetn(resetn), .bus(bus));

  int vecs = 0;
  int errs = 0;

  // Observed strobes: {busy, detect_add, lfd, ld, laf, full, write_enb, rst_int}
  logic [7:0] w_outs;
  assign w_outs = {bus.busy, bus.detect_add, bus.lfd_state, bus.ld_state,
                   bus.laf_state, bus.full_state, bus.write_enb_reg, bus.rst_int_reg};

  localparam logic [7:0] O_DA   = 8'b0100_0000;
  localparam logic [7:0] O_LFD  = 8'b1010_0000;
  localparam logic [7:0] O_LD   = 8'b0001_0010;
  localparam logic [7:0] O_FULL = 8'b1000_0100;
  localparam logic [7:0] O_LAF  = 8'b1000_1010;
  localparam logic [7:0] O_LP   = 8'b1000_0010;
  localparam logic [7:0] O_CPE  = 8'b1000_0001;
  localparam logic [7:0] O_WTE  = 8'b1000_0000;

  // Reference model phases (independent numbering)
  localparam int M_HDR = 10, M_FIRST = 11, M_BODY = 12, M_STALL = 13,
                 M_RESUME = 14, M_PAR = 15, M_CHK = 16, M_WAIT = 17;

  function automatic logic [7:0] m_outs(input int ph);
    case (ph)
      M_FIRST:  return O_LFD;
      M_BODY:   return O_LD;
      M_STALL:  return O_FULL;
      M_RESUME: return O_LAF;
      M_PAR:    return O_LP;
      M_CHK:    return O_CPE;
      M_WAIT:   return O_WTE;
      default:  return O_DA;
    endcase
  endfunction

  task automatic set_in(input logic pv, input logic [1:0] din, input logic [2:0] emp,
                        input logic ff, input logic [2:0] sr, input logic pd, input logic lpv);
    bus.pkt_valid     = pv;
    bus.data_in       = din;
    bus.fifo_empty_0  = emp[0];
    bus.fifo_empty_1  = emp[1];
    bus.fifo_empty_2  = emp[2];
    bus.fifo_full     = ff;
    bus.soft_reset_0  = sr[0];
    bus.soft_reset_1  = sr[1];
    bus.soft_reset_2  = sr[2];
    bus.parity_done   = pd;
    bus.low_pkt_valid = lpv;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    set_in(1'b0, 2'd0, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0);
    resetn = 1'b0;
    tick();
    vecs++;
    if (w_outs !== O_DA) begin errs++; $display("FAIL reset_hold: got %b expected %b", w_outs, O_DA); end
    vecs++;
    if (dut.r_addr_q !== 2'd0) begin errs++; $display("FAIL reset_addr: got %0d expected 0", dut.r_addr_q); end
    resetn = 1'b1;
    tick();
    vecs++;
    if (w_outs !== O_DA) begin errs++; $display("FAIL reset_release: got %b expected %b", w_outs, O_DA); end
  endtask

  task automatic test_normal_pkt;
    logic       pv_seq [8];
    logic [7:0] exp_seq [8];
    pv_seq  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_seq = '{O_LFD, O_LD, O_LD, O_LD, O_LD, O_LP, O_CPE, O_DA};
    for (int i = 0; i < 8; i++) begin
      set_in(pv_seq[i], 2'd1, 3'b010, 1'b0, 3'b000, 1'b0, 1'b0);
      tick();
      vecs++;
      if (w_outs !== exp_seq[i]) begin
        errs++; $display("FAIL normal_pkt step %0d: got %b expected %b", i, w_outs, exp_seq[i]);
      end
    end
    vecs++;
    if (dut.r_addr_q !== 2'd1) begin errs++; $display("FAIL normal_pkt addr: got %0d expected 1", dut.r_addr_q); end
  endtask

  task automatic test_full_stall;
    logic       pv_seq [10];
    logic       ff_seq [10];
    logic [7:0] exp_seq [10];
    // header, first data, full with pkt_valid low (full wins), stall x2,
    // resume, back to data, end packet with parity and check
    pv_seq  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ff_seq  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_seq = '{O_LFD, O_LD, O_FULL, O_FULL, O_FULL, O_LAF, O_LD, O_LP, O_CPE, O_DA};
    for (int i = 0; i < 10; i++) begin
      set_in(pv_seq[i], 2'd0, 3'b001, ff_seq[i], 3'b000, 1'b0, 1'b0);
      tick();
      vecs++;
      if (w_outs !== exp_seq[i]) begin
        errs++; $display("FAIL full_stall step %0d: got %b expected %b", i, w_outs, exp_seq[i]);
      end
    end
  endtask

  task automatic test_wait_empty;
    logic [1:0] din_seq [10];
    logic [2:0] emp_seq [10];
    logic       pv_seq  [10];
    logic [7:0] exp_seq [10];
    // waits on FIFO 2; data_in changes mid-wait must not retarget the check
    din_seq = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    emp_seq = '{3'b011, 3'b011, 3'b001, 3'b001, 3'b011, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    pv_seq  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_seq = '{O_WTE, O_WTE, O_WTE, O_WTE, O_WTE, O_LFD, O_LD, O_LP, O_CPE, O_DA};
    for (int i = 0; i < 10; i++) begin
      set_in(pv_seq[i], din_seq[i], emp_seq[i], 1'b0, 3'b000, 1'b0, 1'b0);
      tick();
      vecs++;
      if (w_outs !== exp_seq[i]) begin
        errs++; $display("FAIL wait_empty step %0d: got %b expected %b", i, w_outs, exp_seq[i]);
      end
    end
  endtask

  task automatic test_soft_reset;
    logic       ff_seq [5];
    logic [2:0] sr_seq [5];
    logic [7:0] exp_seq [5];
    // into LOAD_DATA for port 1; soft_reset_0 ignored; soft_reset_1 with
    // fifo_full wins and returns to decode
    ff_seq  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    sr_seq  = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b000};
    exp_seq = '{O_LFD, O_LD, O_LD, O_DA, O_DA};
    for (int i = 0; i < 5; i++) begin
      set_in((i < 3) ? 1'b1 : 1'b0, 2'd1, 3'b010, ff_seq[i], sr_seq[i], 1'b0, 1'b0);
      tick();
      vecs++;
      if (w_outs !== exp_seq[i]) begin
        errs++; $display("FAIL soft_reset step %0d: got %b expected %b", i, w_outs, exp_seq[i]);
      end
    end
  endtask

  task automatic test_invalid_addr;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 2'd3, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0);
      tick();
      vecs++;
      if (w_outs !== O_DA) begin
        errs++; $display("FAIL invalid_addr step %0d: got %b expected %b", i, w_outs, O_DA);
      end
    end
    vecs++;
    if (dut.r_addr_q !== 2'd3) begin errs++; $display("FAIL invalid_addr latch: got %0d expected 3", dut.r_addr_q); end
  endtask

  task automatic test_async_reset;
    set_in(1'b1, 2'd2, 3'b100, 1'b0, 3'b000, 1'b0, 1'b0);
    tick();
    tick();
    vecs++;
    if (w_outs !== O_LD) begin errs++; $display("FAIL async_reset pre: got %b expected %b", w_outs, O_LD); end
    #2 resetn = 1'b0;
    #1;
    vecs++;
    if (w_outs !== O_DA) begin errs++; $display("FAIL async_reset mid: got %b expected %b", w_outs, O_DA); end
    vecs++;
    if (dut.r_addr_q !== 2'd0) begin errs++; $display("FAIL async_reset addr: got %0d expected 0", dut.r_addr_q); end
    set_in(1'b0, 2'd0, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0);
    tick();
    resetn = 1'b1;
    tick();
    vecs++;
    if (w_outs !== O_DA) begin errs++; $display("FAIL async_reset after: got %b expected %b", w_outs, O_DA); end
  endtask

  task automatic test_random;
    int         ph, nx;
    logic [1:0] ma;
    logic       pv, ff, pd, lpv;
    logic [1:0] din;
    logic [3:0] emp4, sr4;
    int         bad = 0;
    set_in(1'b0, 2'd0, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0);
    do_reset();
    ph = M_HDR;
    ma = 2'd0;
    for (int n = 0; n < 3000; n++) begin
      pv   = ($urandom_range(0, 99) < 80);
      din  = 2'($urandom_range(0, 3));
      emp4 = {1'b0, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6)};
      ff   = ($urandom_range(0, 99) < 20);
      sr4  = {1'b0, ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 3)};
      pd   = ($urandom_range(0, 99) < 30);
      lpv  = ($urandom_range(0, 99) < 30);
      set_in(pv, din, emp4[2:0], ff, sr4[2:0], pd, lpv);
      // reference: packet progress rules
      nx = ph;
      if (ph != M_HDR && sr4[ma]) nx = M_HDR;
      else if (ph == M_HDR)    nx = (pv && din != 2'd3) ? (emp4[din] ? M_FIRST : M_WAIT) : M_HDR;
      else if (ph == M_FIRST)  nx = M_BODY;
      else if (ph == M_BODY)   nx = ff ? M_STALL : (!pv ? M_PAR : M_BODY);
      else if (ph == M_STALL)  nx = ff ? M_STALL : M_RESUME;
      else if (ph == M_RESUME) nx = pd ? M_HDR : (lpv ? M_PAR : M_BODY);
      else if (ph == M_PAR)    nx = M_CHK;
      else if (ph == M_CHK)    nx = ff ? M_STALL : M_HDR;
      else if (ph == M_WAIT)   nx = emp4[ma] ? M_FIRST : M_WAIT;
      if (ph == M_HDR && pv) ma = din;
      ph = nx;
      tick();
      vecs++;
      if (w_outs !== m_outs(ph) || dut.r_addr_q !== ma) begin
        errs++;
        if (bad < 10)
          $display("FAIL random cycle %0d: got %b addr %0d expected %b addr %0d",
                   n, w_outs, dut.r_addr_q, m_outs(ph), ma);
        bad++;
      end
    end
  endtask

  initial begin
    set_in(1'b0, 2'd0, 3'b111, 1'b0, 3'b000, 1'b0, 1'b0);
    test_reset();
    test_normal_pkt();
    test_full_stall();
    test_wait_empty();
    test_soft_reset();
    test_invalid_addr();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Packet-level controller for the 1x3 router.
- Sequences each incoming packet: header decode, first-data load, payload load, full-stall, parity load and parity check.
- Drives router_sync (detect_add, write_enb_reg) and the register block (lfd/ld/laf/full/rst_int strobes). Asserts busy back to the source.
- Sits between the input port and the register/sync/FIFO datapath. Owns no data storage except the latched destination address.

Parameters:
- None. Address width is fixed at 2 bits; destinations 0..2 are valid; address 3 is invalid.

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- pkt_valid  in  1  source is presenting packet bytes; deasserts at the parity byte
- data_in  in  2  header address bits [1:0], sampled in DECODE_ADDRESS
- parity_done  in  1  register block has captured the parity byte
- low_pkt_valid  in  1  register block saw pkt_valid fall while stalled
- fifo_full  in  1  selected FIFO is full (muxed by router_sync)
- fifo_empty_0/1/2  in  1 each  per-FIFO empty flag
- soft_reset_0/1/2  in  1 each  per-FIFO timeout soft reset from router_sync
- busy  out  1  stall request to the source
- detect_add  out  1  header decode strobe
- lfd_state  out  1  load-first-data strobe
- ld_state  out  1  load-data strobe
- laf_state  out  1  load-after-full strobe
- full_state  out  1  FIFO-full stall strobe
- write_enb_reg  out  1  FIFO write qualifier
- rst_int_reg  out  1  clears internal parity/error registers

Behaviour:
- Moore FSM with 8 states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
- State register is asynchronous-reset to DECODE_ADDRESS. Next-state logic is combinational; the state updates on the rising clock edge.
- addr_q (2b) loads data_in when state==DECODE_ADDRESS && pkt_valid. It holds otherwise. It resets to 0.
- empty_sel = fifo_empty[addr_q]; soft_sel = soft_reset[addr_q].
- In DECODE_ADDRESS, the empty/soft-reset checks use data_in directly, not addr_q.
- Transitions (priority top-down):
  - Any state except DECODE_ADDRESS: soft_sel=1 -> DECODE_ADDRESS. This overrides every transition below.
  - DECODE_ADDRESS:
    - pkt_valid && data_in<3 && fifo_empty[data_in] -> LOAD_FIRST_DATA
    - pkt_valid && data_in<3 && !fifo_empty[data_in] -> WAIT_TILL_EMPTY
    - otherwise stay. pkt_valid with data_in==3 is dropped: no write, busy stays 0.
  - LOAD_FIRST_DATA -> LOAD_DATA unconditionally, after exactly 1 cycle.
  - LOAD_DATA:
    - fifo_full -> FIFO_FULL_STATE
    - else !pkt_valid -> LOAD_PARITY
    - else stay
  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS
    - else low_pkt_valid -> LOAD_PARITY
    - else -> LOAD_DATA
  - LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
  - WAIT_TILL_EMPTY: empty_sel -> LOAD_FIRST_DATA; else stay.
- Outputs are a pure decode of the state (no extra latency):
  - detect_add = DECODE_ADDRESS
  - lfd_state = LOAD_FIRST_DATA
  - ld_state = LOAD_DATA
  - full_state = FIFO_FULL_STATE
  - laf_state = LOAD_AFTER_FULL
  - write_enb_reg = LOAD_DATA | LOAD_AFTER_FULL | LOAD_PARITY
  - rst_int_reg = CHECK_PARITY_ERROR
  - busy = every state except DECODE_ADDRESS and LOAD_DATA
- Reset values of outputs: detect_add=1, all other outputs=0. This holds during and immediately after resetn low.
- Reset mid-packet:
  - resetn low forces DECODE_ADDRESS asynchronously.
  - Partial packet is abandoned; FIFO cleanup is the FIFO's own reset.
- Simultaneous events:
  - soft reset and fifo_full in the same cycle: soft reset wins.
  - fifo_full and !pkt_valid in LOAD_DATA: fifo_full wins.

Decomposition:
- router_pkg holds:
  - state enum (3-bit binary encoding, DECODE_ADDRESS=0)
  - address constants ADDR_P0=0, ADDR_P1=1, ADDR_P2=2, ADDR_INVALID=3
- No sub-module. The address latch and per-port selection muxes stay inline.

Test Plan:
- Reset: resetn=0 for 1 cycle, then 1 -> detect_add=1, busy=0, write_enb_reg=0, addr_q=0.
- Normal packet to port 1:
  - Stimulus: pkt_valid=1, data_in=01, fifo_empty_1=1, then 4 payload cycles, then pkt_valid=0.
  - Response: lfd_state=1 for 1 cycle with busy=1; ld_state=1 for 4 cycles with busy=0; LOAD_PARITY for 1 cycle (write_enb_reg=1, busy=1); rst_int_reg=1 for 1 cycle; back to detect_add=1.
- Full stall:
  - Stimulus: in LOAD_DATA, fifo_full=1 for 3 cycles, then 0, with parity_done=0 and low_pkt_valid=0.
  - Response: full_state=1 for 3 cycles with busy=1 and write_enb_reg=0; laf_state=1 for 1 cycle; return to LOAD_DATA.
- Wait for empty:
  - Stimulus: data_in=10, pkt_valid=1, fifo_empty_2=0 for 5 cycles, then 1.
  - Response: WAIT_TILL_EMPTY with busy=1 and write_enb_reg=0 for 5 cycles; then lfd_state=1.
- Soft reset: soft_reset_1=1 while in LOAD_DATA for addr 01 -> detect_add=1 on the next cycle. soft_reset_0=1 in the same situation has no effect.
- Invalid address: pkt_valid=1, data_in=11 -> FSM stays in DECODE_ADDRESS; busy=0 and write_enb_reg=0 throughout.
